// File: rtl/wb_host_master_if.sv
// Command/response stream and Wishbone bus bundle for the host master.
// The master modport is the host-master view; slave is the environment view.
`timescale 1ns/1ps
interface wb_host_master_if;
   logic        cmd_valid_i;
   logic        cmd_ready_o;
   logic        cmd_we_i;
   logic [9:0]  cmd_adr_i;
   logic [3:0]  cmd_sel_i;
   logic [31:0] cmd_wdata_i;

   logic        rsp_valid_o;
   logic        rsp_ready_i;
   logic [31:0] rsp_rdata_o;
   logic        rsp_err_o;
   logic        rsp_timeout_o;

   logic [9:0]  wb_adr_o;
   logic [31:0] wb_dat_o;
   logic [31:0] wb_dat_i;
   logic [3:0]  wb_sel_o;
   logic        wb_we_o;
   logic        wb_cyc_o;
   logic        wb_stb_o;
   logic        wb_ack_i;
   logic        wb_err_i;

   modport master (
      input  cmd_valid_i, cmd_we_i, cmd_adr_i, cmd_sel_i, cmd_wdata_i,
      output cmd_ready_o,
      output rsp_valid_o, rsp_rdata_o, rsp_err_o, rsp_timeout_o,
      input  rsp_ready_i,
      output wb_adr_o, wb_dat_o, wb_sel_o, wb_we_o, wb_cyc_o, wb_stb_o,
      input  wb_dat_i, wb_ack_i, wb_err_i
   );

   modport slave (
      output cmd_valid_i, cmd_we_i, cmd_adr_i, cmd_sel_i, cmd_wdata_i,
      input  cmd_ready_o,
      input  rsp_valid_o, rsp_rdata_o, rsp_err_o, rsp_timeout_o,
      output rsp_ready_i,
      input  wb_adr_o, wb_dat_o, wb_sel_o, wb_we_o, wb_cyc_o, wb_stb_o,
      output wb_dat_i, wb_ack_i, wb_err_i
   );
endinterface

// File: rtl/wb_host_master.sv
// Wishbone classic single-cycle host master: one command in, one bus cycle,
// one response out, with optional wait timeout and a registered interrupt edge.
`timescale 1ns/1ps
module wb_host_master #(
   parameter  int TIMEOUT_CYCLES = 256,
   localparam int CNT_W = ($clog2(TIMEOUT_CYCLES + 1) < 1) ? 1 : $clog2(TIMEOUT_CYCLES + 1)
) (
   input  logic                  wb_clk_i,
   input  logic                  wb_rst_i,
   wb_host_master_if.master      bus,
   input  logic                  int_i,
   output logic                  irq_o,
   output logic                  irq_rise_o
);

   typedef enum logic [1:0] {IDLE, BUS, RESP} state_e;

   localparam bit             TO_EN   = (TIMEOUT_CYCLES != 0);
   localparam logic [CNT_W-1:0] TO_LAST = CNT_W'((TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1);

   state_e           state_q, state_d;
   logic [9:0]       wb_adr_q, wb_adr_d;
   logic [31:0]      wb_dat_q, wb_dat_d;
   logic [3:0]       wb_sel_q, wb_sel_d;
   logic             wb_we_q, wb_we_d;
   logic             wb_cyc_q, wb_cyc_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             rsp_valid_q, rsp_valid_d;
   logic [31:0]      rsp_rdata_q, rsp_rdata_d;
   logic             rsp_err_q, rsp_err_d;
   logic             rsp_timeout_q, rsp_timeout_d;
   logic             irq_q, irq_d;
   logic             irq_rise_q, irq_rise_d;

   always_comb begin
      state_d       = state_q;
      wb_adr_d      = wb_adr_q;
      wb_dat_d      = wb_dat_q;
      wb_sel_d      = wb_sel_q;
      wb_we_d       = wb_we_q;
      wb_cyc_d      = wb_cyc_q;
      cnt_d         = cnt_q;
      rsp_valid_d   = rsp_valid_q;
      rsp_rdata_d   = rsp_rdata_q;
      rsp_err_d     = rsp_err_q;
      rsp_timeout_d = rsp_timeout_q;

      unique case (state_q)
         IDLE: begin
            if (bus.cmd_valid_i) begin
               wb_adr_d = bus.cmd_adr_i;
               wb_dat_d = bus.cmd_wdata_i;
               wb_sel_d = bus.cmd_sel_i;
               wb_we_d  = bus.cmd_we_i;
               wb_cyc_d = 1'b1;
               cnt_d    = '0;
               state_d  = BUS;
            end
         end
         BUS: begin
            // err wins over a simultaneous ack; timeout only when the slave is silent
            if (bus.wb_err_i || bus.wb_ack_i || (TO_EN && cnt_q == TO_LAST)) begin
               wb_cyc_d    = 1'b0;
               wb_we_d     = 1'b0;
               rsp_valid_d = 1'b1;
               state_d     = RESP;
               if (bus.wb_err_i) begin
                  rsp_err_d   = 1'b1;
                  rsp_rdata_d = '0;
               end else if (bus.wb_ack_i) begin
                  rsp_err_d   = 1'b0;
                  rsp_rdata_d = wb_we_q ? 32'h0 : bus.wb_dat_i;
               end else begin
                  rsp_err_d     = 1'b1;
                  rsp_timeout_d = 1'b1;
                  rsp_rdata_d   = '0;
               end
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         RESP: begin
            if (bus.rsp_ready_i) begin
               rsp_valid_d   = 1'b0;
               rsp_rdata_d   = '0;
               rsp_err_d     = 1'b0;
               rsp_timeout_d = 1'b0;
               state_d       = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      irq_d      = int_i;
      irq_rise_d = int_i & ~irq_q;
   end

   always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
      if (!wb_rst_i) begin
         state_q       <= IDLE;
         wb_adr_q      <= '0;
         wb_dat_q      <= '0;
         wb_sel_q      <= '0;
         wb_we_q       <= 1'b0;
         wb_cyc_q      <= 1'b0;
         cnt_q         <= '0;
         rsp_valid_q   <= 1'b0;
         rsp_rdata_q   <= '0;
         rsp_err_q     <= 1'b0;
         rsp_timeout_q <= 1'b0;
         irq_q         <= 1'b0;
         irq_rise_q    <= 1'b0;
      end else begin
         state_q       <= state_d;
         wb_adr_q      <= wb_adr_d;
         wb_dat_q      <= wb_dat_d;
         wb_sel_q      <= wb_sel_d;
         wb_we_q       <= wb_we_d;
         wb_cyc_q      <= wb_cyc_d;
         cnt_q         <= cnt_d;
         rsp_valid_q   <= rsp_valid_d;
         rsp_rdata_q   <= rsp_rdata_d;
         rsp_err_q     <= rsp_err_d;
         rsp_timeout_q <= rsp_timeout_d;
         irq_q         <= irq_d;
         irq_rise_q    <= irq_rise_d;
      end
   end

   assign bus.cmd_ready_o   = (state_q == IDLE);
   assign bus.rsp_valid_o   = rsp_valid_q;
   assign bus.rsp_rdata_o   = rsp_rdata_q;
   assign bus.rsp_err_o     = rsp_err_q;
   assign bus.rsp_timeout_o = rsp_timeout_q;
   assign bus.wb_adr_o      = wb_adr_q;
   assign bus.wb_dat_o      = wb_dat_q;
   assign bus.wb_sel_o      = wb_sel_q;
   assign bus.wb_we_o       = wb_we_q;
   assign bus.wb_cyc_o      = wb_cyc_q;
   assign bus.wb_stb_o      = wb_cyc_q;
   assign irq_o             = irq_q;
   assign irq_rise_o        = irq_rise_q;

endmodule

// File: tb/tb_wb_host_master.sv
// Directed bench for wb_host_master: two instances, timeout of 16 and timeout disabled.
`timescale 1ns/1ps
module tb_wb_host_master;
   logic wb_clk_i = 1'b0;
   logic wb_rst_i = 1'b0;
   logic int_i    = 1'b0;
   logic irq_o, irq_rise_o, irq0_o, irq0_rise_o;
   int   vectors = 0;
   int   miscompares = 0;

   wb_host_master_if ifc ();
   wb_host_master_if ifc0 ();

   wb_host_master #(.TIMEOUT_CYCLES(16)) dut (
      .wb_clk_i(wb_clk_i), .wb_rst_i(wb_rst_i), .bus(ifc),
      .int_i(int_i), .irq_o(irq_o), .irq_rise_o(irq_rise_o));

   wb_host_master #(.TIMEOUT_CYCLES(0)) dut0 (
      .wb_clk_i(wb_clk_i), .wb_rst_i(wb_rst_i), .bus(ifc0),
      .int_i(1'b0), .irq_o(irq0_o), .irq_rise_o(irq0_rise_o));

   always #5 wb_clk_i = ~wb_clk_i;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // Drive one command at a negedge while idle; returns at the next negedge.
   task automatic issue(input logic we, input logic [9:0] adr,
                        input logic [3:0] sel, input logic [31:0] wd);
      ifc.cmd_valid_i = 1'b1;
      ifc.cmd_we_i    = we;
      ifc.cmd_adr_i   = adr;
      ifc.cmd_sel_i   = sel;
      ifc.cmd_wdata_i = wd;
      @(negedge wb_clk_i);
      ifc.cmd_valid_i = 1'b0;
   endtask

   task automatic release_rsp;
      ifc.rsp_ready_i = 1'b1;
      @(negedge wb_clk_i);
      ifc.rsp_ready_i = 1'b0;
   endtask

   task automatic test_reset;
      @(negedge wb_clk_i);
      vectors++;
      if ({ifc.cmd_ready_o, ifc.wb_cyc_o, ifc.wb_stb_o, ifc.wb_we_o, ifc.rsp_valid_o,
           ifc.rsp_err_o, ifc.rsp_timeout_o, irq_o, irq_rise_o} !== 9'b1_0000_0000) begin
         miscompares++;
         $display("FAIL reset_ctrl: got %b expected 100000000",
                  {ifc.cmd_ready_o, ifc.wb_cyc_o, ifc.wb_stb_o, ifc.wb_we_o, ifc.rsp_valid_o,
                   ifc.rsp_err_o, ifc.rsp_timeout_o, irq_o, irq_rise_o});
      end
      vectors++;
      if ({ifc.wb_adr_o, ifc.wb_dat_o, ifc.wb_sel_o, ifc.rsp_rdata_o} !== 78'h0) begin
         miscompares++;
         $display("FAIL reset_data: got %h expected 0",
                  {ifc.wb_adr_o, ifc.wb_dat_o, ifc.wb_sel_o, ifc.rsp_rdata_o});
      end
      wb_rst_i = 1'b1;
      @(negedge wb_clk_i);
   endtask

   task automatic test_ignore_idle_ack;
      ifc.wb_ack_i = 1'b1;
      ifc.wb_err_i = 1'b1;
      @(negedge wb_clk_i);
      ifc.wb_ack_i = 1'b0;
      ifc.wb_err_i = 1'b0;
      vectors++;
      if ({ifc.rsp_valid_o, ifc.wb_cyc_o, ifc.cmd_ready_o} !== 3'b001) begin
         miscompares++;
         $display("FAIL idle_ack_ignored: got %b expected 001",
                  {ifc.rsp_valid_o, ifc.wb_cyc_o, ifc.cmd_ready_o});
      end
   endtask

   task automatic test_write_moder;
      int hi = 0;
      issue(1'b1, 10'h000, 4'hF, 32'h0000_A000);
      vectors++;
      if ({ifc.wb_we_o, ifc.wb_sel_o, ifc.wb_adr_o, ifc.wb_dat_o, ifc.cmd_ready_o}
          !== {1'b1, 4'hF, 10'h000, 32'h0000_A000, 1'b0}) begin
         miscompares++;
         $display("FAIL write_bus_fields: got we=%b sel=%h adr=%h dat=%h rdy=%b expected 1 f 000 0000a000 0",
                  ifc.wb_we_o, ifc.wb_sel_o, ifc.wb_adr_o, ifc.wb_dat_o, ifc.cmd_ready_o);
      end
      for (int i = 0; i < 3; i++) begin
         if (ifc.wb_cyc_o === 1'b1 && ifc.wb_stb_o === 1'b1) hi++;
         if (i == 2) ifc.wb_ack_i = 1'b1;
         @(negedge wb_clk_i);
      end
      ifc.wb_ack_i = 1'b0;
      vectors++;
      if (hi !== 3 || ifc.wb_cyc_o !== 1'b0 || ifc.wb_we_o !== 1'b0) begin
         miscompares++;
         $display("FAIL write_cyc_len: got hi=%0d cyc=%b we=%b expected 3 0 0", hi, ifc.wb_cyc_o, ifc.wb_we_o);
      end
      vectors++;
      if ({ifc.rsp_valid_o, ifc.rsp_err_o, ifc.rsp_timeout_o, ifc.rsp_rdata_o} !== {3'b100, 32'h0}) begin
         miscompares++;
         $display("FAIL write_rsp: got v=%b e=%b t=%b d=%h expected 1 0 0 00000000",
                  ifc.rsp_valid_o, ifc.rsp_err_o, ifc.rsp_timeout_o, ifc.rsp_rdata_o);
      end
      vectors++;
      if (ifc.wb_dat_o !== 32'h0000_A000) begin
         miscompares++;
         $display("FAIL write_dat_held: got %h expected 0000a000", ifc.wb_dat_o);
      end
      release_rsp();
      vectors++;
      if ({ifc.rsp_valid_o, ifc.cmd_ready_o} !== 2'b01) begin
         miscompares++;
         $display("FAIL write_release: got v=%b rdy=%b expected 0 1", ifc.rsp_valid_o, ifc.cmd_ready_o);
      end
   endtask

   task automatic test_read_zero_wait;
      int bad = 0;
      issue(1'b0, 10'h010, 4'hF, 32'h0);
      ifc.wb_dat_i = 32'h1234_5678;
      ifc.wb_ack_i = 1'b1;
      @(negedge wb_clk_i);
      ifc.wb_ack_i = 1'b0;
      ifc.wb_dat_i = 32'hDEAD_BEEF;
      vectors++;
      if ({ifc.wb_cyc_o, ifc.wb_stb_o, ifc.rsp_valid_o, ifc.rsp_err_o} !== 4'b0010
          || ifc.rsp_rdata_o !== 32'h1234_5678) begin
         miscompares++;
         $display("FAIL read_zero_wait: got cyc=%b stb=%b v=%b e=%b d=%h expected 0 0 1 0 12345678",
                  ifc.wb_cyc_o, ifc.wb_stb_o, ifc.rsp_valid_o, ifc.rsp_err_o, ifc.rsp_rdata_o);
      end
      // a command offered during RESP must not start a cycle
      ifc.cmd_valid_i = 1'b1;
      ifc.cmd_we_i    = 1'b1;
      ifc.cmd_adr_i   = 10'h155;
      for (int i = 0; i < 4; i++) begin
         @(negedge wb_clk_i);
         if (ifc.rsp_valid_o !== 1'b1 || ifc.rsp_rdata_o !== 32'h1234_5678 ||
             ifc.cmd_ready_o !== 1'b0 || ifc.wb_cyc_o !== 1'b0) bad++;
      end
      ifc.cmd_valid_i = 1'b0;
      vectors++;
      if (bad !== 0) begin
         miscompares++;
         $display("FAIL read_rsp_hold: got %0d bad cycles expected 0", bad);
      end
      release_rsp();
      vectors++;
      if ({ifc.rsp_valid_o, ifc.cmd_ready_o, ifc.wb_cyc_o, ifc.wb_adr_o} !== {3'b010, 10'h010}) begin
         miscompares++;
         $display("FAIL read_release: got v=%b rdy=%b cyc=%b adr=%h expected 0 1 0 010",
                  ifc.rsp_valid_o, ifc.cmd_ready_o, ifc.wb_cyc_o, ifc.wb_adr_o);
      end
   endtask

   task automatic test_error;
      issue(1'b0, 10'h3FF, 4'hF, 32'h0);
      vectors++;
      if (ifc.wb_adr_o !== 10'h3FF) begin
         miscompares++;
         $display("FAIL err_adr: got %h expected 3ff", ifc.wb_adr_o);
      end
      ifc.wb_dat_i = 32'hFFFF_FFFF;
      ifc.wb_ack_i = 1'b1;
      ifc.wb_err_i = 1'b1;
      @(negedge wb_clk_i);
      ifc.wb_ack_i = 1'b0;
      ifc.wb_err_i = 1'b0;
      vectors++;
      if ({ifc.wb_cyc_o, ifc.rsp_valid_o, ifc.rsp_err_o, ifc.rsp_timeout_o} !== 4'b0110
          || ifc.rsp_rdata_o !== 32'h0) begin
         miscompares++;
         $display("FAIL err_rsp: got cyc=%b v=%b e=%b t=%b d=%h expected 0 1 1 0 00000000",
                  ifc.wb_cyc_o, ifc.rsp_valid_o, ifc.rsp_err_o, ifc.rsp_timeout_o, ifc.rsp_rdata_o);
      end
      release_rsp();
      vectors++;
      if ({ifc.rsp_valid_o, ifc.rsp_err_o, ifc.cmd_ready_o} !== 3'b001) begin
         miscompares++;
         $display("FAIL err_release: got v=%b e=%b rdy=%b expected 0 0 1",
                  ifc.rsp_valid_o, ifc.rsp_err_o, ifc.cmd_ready_o);
      end
   endtask

   task automatic test_timeout;
      int hi = 0;
      int bad = 0;
      issue(1'b0, 10'h020, 4'h1, 32'h0);
      while (ifc.wb_cyc_o === 1'b1 && hi < 40) begin
         hi++;
         @(negedge wb_clk_i);
      end
      vectors++;
      if (hi !== 16) begin
         miscompares++;
         $display("FAIL timeout_len: got %0d cycles expected 16", hi);
      end
      vectors++;
      if ({ifc.rsp_valid_o, ifc.rsp_err_o, ifc.rsp_timeout_o} !== 3'b111 || ifc.rsp_rdata_o !== 32'h0) begin
         miscompares++;
         $display("FAIL timeout_rsp: got v=%b e=%b t=%b d=%h expected 1 1 1 00000000",
                  ifc.rsp_valid_o, ifc.rsp_err_o, ifc.rsp_timeout_o, ifc.rsp_rdata_o);
      end
      release_rsp();
      vectors++;
      if ({ifc.rsp_timeout_o, ifc.rsp_err_o, ifc.cmd_ready_o} !== 3'b001) begin
         miscompares++;
         $display("FAIL timeout_release: got t=%b e=%b rdy=%b expected 0 0 1",
                  ifc.rsp_timeout_o, ifc.rsp_err_o, ifc.cmd_ready_o);
      end
      // timeout disabled: the cycle must stay open indefinitely
      ifc0.cmd_valid_i = 1'b1;
      ifc0.cmd_adr_i   = 10'h030;
      @(negedge wb_clk_i);
      ifc0.cmd_valid_i = 1'b0;
      for (int i = 0; i < 1000; i++) begin
         if (ifc0.wb_cyc_o !== 1'b1 || ifc0.wb_stb_o !== 1'b1 || ifc0.rsp_valid_o !== 1'b0) bad++;
         @(negedge wb_clk_i);
      end
      vectors++;
      if (bad !== 0) begin
         miscompares++;
         $display("FAIL no_timeout_hold: got %0d bad cycles expected 0", bad);
      end
   endtask

   task automatic test_reset_mid_cycle;
      issue(1'b0, 10'h040, 4'hF, 32'h0);
      @(negedge wb_clk_i);
      @(negedge wb_clk_i);
      #2 wb_rst_i = 1'b0;
      #1;
      vectors++;
      if ({ifc.wb_cyc_o, ifc.wb_stb_o, ifc.rsp_valid_o, ifc.cmd_ready_o, ifc0.wb_cyc_o} !== 5'b00010) begin
         miscompares++;
         $display("FAIL reset_async: got cyc=%b stb=%b v=%b rdy=%b cyc0=%b expected 0 0 0 1 0",
                  ifc.wb_cyc_o, ifc.wb_stb_o, ifc.rsp_valid_o, ifc.cmd_ready_o, ifc0.wb_cyc_o);
      end
      @(negedge wb_clk_i);
      wb_rst_i = 1'b1;
      @(negedge wb_clk_i);
      vectors++;
      if ({ifc.cmd_ready_o, ifc.wb_cyc_o} !== 2'b10) begin
         miscompares++;
         $display("FAIL reset_release: got rdy=%b cyc=%b expected 1 0", ifc.cmd_ready_o, ifc.wb_cyc_o);
      end
      issue(1'b1, 10'h044, 4'h3, 32'hCAFE_F00D);
      vectors++;
      if ({ifc.wb_cyc_o, ifc.wb_we_o, ifc.wb_sel_o, ifc.wb_adr_o, ifc.wb_dat_o}
          !== {2'b11, 4'h3, 10'h044, 32'hCAFE_F00D}) begin
         miscompares++;
         $display("FAIL post_reset_write_bus: got cyc=%b we=%b sel=%h adr=%h dat=%h expected 1 1 3 044 cafef00d",
                  ifc.wb_cyc_o, ifc.wb_we_o, ifc.wb_sel_o, ifc.wb_adr_o, ifc.wb_dat_o);
      end
      ifc.wb_ack_i = 1'b1;
      @(negedge wb_clk_i);
      ifc.wb_ack_i = 1'b0;
      vectors++;
      if ({ifc.wb_cyc_o, ifc.rsp_valid_o, ifc.rsp_err_o} !== 3'b010 || ifc.rsp_rdata_o !== 32'h0) begin
         miscompares++;
         $display("FAIL post_reset_write_rsp: got cyc=%b v=%b e=%b d=%h expected 0 1 0 00000000",
                  ifc.wb_cyc_o, ifc.rsp_valid_o, ifc.rsp_err_o, ifc.rsp_rdata_o);
      end
      release_rsp();
   endtask

   task automatic test_back_to_back;
      int hi = 0;
      int rv = 0;
      ifc.rsp_ready_i = 1'b1;
      ifc.cmd_valid_i = 1'b1;
      ifc.cmd_we_i    = 1'b0;
      ifc.cmd_adr_i   = 10'h008;
      for (int i = 1; i <= 12; i++) begin
         @(negedge wb_clk_i);
         if (ifc.wb_cyc_o === 1'b1) hi++;
         if (ifc.rsp_valid_o === 1'b1) rv++;
         ifc.wb_ack_i = ifc.wb_cyc_o;
         if (i == 12) ifc.cmd_valid_i = 1'b0;
      end
      @(negedge wb_clk_i);
      ifc.wb_ack_i    = 1'b0;
      ifc.rsp_ready_i = 1'b0;
      vectors++;
      if (hi !== 4 || rv !== 4) begin
         miscompares++;
         $display("FAIL b2b_rate: got cyc=%0d rsp=%0d expected 4 4", hi, rv);
      end
      vectors++;
      if ({ifc.cmd_ready_o, ifc.wb_cyc_o, ifc.rsp_valid_o} !== 3'b100) begin
         miscompares++;
         $display("FAIL b2b_idle: got rdy=%b cyc=%b v=%b expected 1 0 0",
                  ifc.cmd_ready_o, ifc.wb_cyc_o, ifc.rsp_valid_o);
      end
   endtask

   task automatic test_interrupt;
      logic [6:0] irq_seen  = '0;
      logic [6:0] rise_seen = '0;
      int_i = 1'b1;
      for (int k = 0; k < 7; k++) begin
         @(negedge wb_clk_i);
         irq_seen[k]  = irq_o;
         rise_seen[k] = irq_rise_o;
         if (k == 4) int_i = 1'b0;
      end
      vectors++;
      if (irq_seen !== 7'b0011111) begin
         miscompares++;
         $display("FAIL irq_level: got %b expected 0011111", irq_seen);
      end
      vectors++;
      if (rise_seen !== 7'b0000001) begin
         miscompares++;
         $display("FAIL irq_rise_first: got %b expected 0000001", rise_seen);
      end
      int_i = 1'b1;
      @(negedge wb_clk_i);
      vectors++;
      if ({irq_o, irq_rise_o} !== 2'b11) begin
         miscompares++;
         $display("FAIL irq_rise_second: got irq=%b rise=%b expected 1 1", irq_o, irq_rise_o);
      end
      @(negedge wb_clk_i);
      int_i = 1'b0;
      vectors++;
      if ({irq_o, irq_rise_o} !== 2'b10) begin
         miscompares++;
         $display("FAIL irq_rise_width: got irq=%b rise=%b expected 1 0", irq_o, irq_rise_o);
      end
   endtask

   initial begin
      ifc.cmd_valid_i  = 1'b0; ifc.cmd_we_i  = 1'b0; ifc.cmd_adr_i  = '0;
      ifc.cmd_sel_i    = '0;   ifc.cmd_wdata_i = '0; ifc.rsp_ready_i = 1'b0;
      ifc.wb_dat_i     = '0;   ifc.wb_ack_i  = 1'b0; ifc.wb_err_i   = 1'b0;
      ifc0.cmd_valid_i = 1'b0; ifc0.cmd_we_i = 1'b0; ifc0.cmd_adr_i = '0;
      ifc0.cmd_sel_i   = '0;   ifc0.cmd_wdata_i = '0; ifc0.rsp_ready_i = 1'b0;
      ifc0.wb_dat_i    = '0;   ifc0.wb_ack_i = 1'b0; ifc0.wb_err_i  = 1'b0;

      test_reset();
      test_ignore_idle_ack();
      test_write_moder();
      test_read_zero_wait();
      test_error();
      test_timeout();
      test_reset_mid_cycle();
      test_back_to_back();
      test_interrupt();

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
